// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the ID-stage branch resolve unit.
//   state_t          : FSM state encoding (IDLE=0, STALL=1, RESOLVE=2)
//   LOAD_STALL_DEPTH : stall cycles needed behind a load in EX
//   ALU_STALL_DEPTH  : stall cycles needed behind an ALU op in EX or a load in MEM
//   reg_match()      : register-number hazard compare, $zero never matches
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STALL   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam logic [1:0] LOAD_STALL_DEPTH = 2'd2;
  localparam logic [1:0] ALU_STALL_DEPTH  = 2'd1;

  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_hazard_detect.sv
// branch_hazard_detect: combinational stall-depth calculation for a branch
// whose operands are read in ID.
// Ports:
//   id_rs, id_rt       in  5  branch source registers
//   ex_regwrite        in  1  EX instruction writes a register
//   ex_memread         in  1  EX instruction is a load
//   ex_rd              in  5  EX destination
//   mem_memread        in  1  MEM instruction is a load
//   mem_rd             in  5  MEM destination
//   stall_count        out 2  cycles to wait before operands are forwardable
module branch_hazard_detect
  import branch_resolve_unit_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       mem_memread,
  input  logic [4:0] mem_rd,
  output logic [1:0] stall_count
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = reg_match(ex_rd, id_rs)  || reg_match(ex_rd, id_rt);
  assign mem_hit = reg_match(mem_rd, id_rs) || reg_match(mem_rd, id_rt);

  // Priority order yields the maximum of the individual requirements.
  always_comb begin
    stall_count = 2'd0;
    if (ex_memread && ex_hit)
      stall_count = LOAD_STALL_DEPTH;
    else if ((ex_regwrite && ex_hit) || (mem_memread && mem_hit))
      stall_count = ALU_STALL_DEPTH;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves beq/bne in ID, stalling until operands can be
// forwarded, then redirects the PC when the branch is taken.
// Optional feature macro: BRANCH_STATS_EN adds resolved/taken branch counters.
// Ports:
//   clk, reset                 in  1   clock, synchronous active-high reset
//   id_beq, id_bne             in  1   ID holds beq / bne (both => beq)
//   id_rs, id_rt               in  5   source register numbers
//   rs_val, rt_val             in  32  forwarded operand values
//   id_target                  in  32  computed branch target
//   ex_regwrite, ex_memread    in  1   EX-stage controls
//   ex_rd                      in  5   EX destination
//   mem_memread                in  1   MEM-stage load flag
//   mem_rd                     in  5   MEM destination
//   ext_flush                  in  1   external flush of ID
//   stall                      out 1   freeze PC and IF/ID
//   flush                      out 1   clear IF/ID
//   pc_src                     out 1   select branch_target
//   branch_target              out 32  redirect address
//   branch_cnt, taken_cnt      out 32  (BRANCH_STATS_EN only) statistics
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_beq,
  input  logic        id_bne,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] id_target,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  input  logic        ext_flush,
  output logic        stall,
  output logic        flush,
  output logic        pc_src,
  output logic [31:0] branch_target
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] branch_cnt,
  output logic [31:0] taken_cnt
`endif
);

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic       is_bne, is_bne_next;
  logic [1:0] need;
  logic       branch;
  logic       id_is_bne;
  logic       operands_eq;
  logic       stall_req;
  logic       taken;

  branch_hazard_detect u_hazard (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_regwrite (ex_regwrite),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .mem_memread (mem_memread),
    .mem_rd      (mem_rd),
    .stall_count (need)
  );

  assign branch      = id_beq || id_bne;
  assign id_is_bne   = id_bne && !id_beq;
  assign operands_eq = (rs_val == rt_val);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      is_bne <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      is_bne <= is_bne_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    is_bne_next = is_bne;
    stall_req   = 1'b0;
    taken       = 1'b0;
    case (state)
      IDLE: begin
        if (branch && !ext_flush) begin
          if (need == 2'd0) begin
            taken = id_is_bne ? !operands_eq : operands_eq;
          end else begin
            stall_req   = 1'b1;
            cnt_next    = need - 2'd1;
            is_bne_next = id_is_bne;
            state_next  = STALL;
          end
        end
      end
      STALL: begin
        if (ext_flush) begin
          cnt_next   = 2'd0;
          state_next = IDLE;
        end else begin
          stall_req = 1'b1;
          if (cnt == 2'd0) state_next = RESOLVE;
          else             cnt_next   = cnt - 2'd1;
        end
      end
      RESOLVE: begin
        // Branch type was captured at detection; ID is frozen meanwhile.
        state_next = IDLE;
        if (!ext_flush) taken = is_bne ? !operands_eq : operands_eq;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, independent of the inputs.
  assign stall         = !reset && stall_req;
  assign pc_src        = !reset && taken;
  assign flush         = !reset && taken;
  assign branch_target = reset ? 32'd0 : id_target;

`ifdef BRANCH_STATS_EN
  logic resolved;

  assign resolved = !ext_flush &&
                    (((state == IDLE) && branch && (need == 2'd0)) ||
                     (state == RESOLVE));

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt <= 32'd0;
      taken_cnt  <= 32'd0;
    end else begin
      if (resolved) branch_cnt <= branch_cnt + 32'd1;
      if (taken)    taken_cnt  <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule
